// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-RAM arbiter: read-return owner encoding and
// the width of the VGA anti-starvation wait counter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VGA  = 2'd2,
    OWN_DBG  = 2'd3
  } owner_t;

  localparam int WAIT_W = 8;

endpackage

// File: rtl/dmem_arbiter_prio3.sv
// Pure combinational three-way priority picker: CPU > VGA > DBG, with VGA
// lifted above CPU while promote is set.
module arb_prio3 (
  input  logic cpu_req,
  input  logic vga_req,
  input  logic dbg_req,
  input  logic promote,
  output logic cpu_gnt,
  output logic vga_gnt,
  output logic dbg_gnt
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    cpu_gnt = 1'b0;
    vga_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (promote && vga_req)  vga_gnt = 1'b1;
    else if (cpu_req)        cpu_gnt = 1'b1;
    else if (vga_req)        vga_gnt = 1'b1;
    else if (dbg_req)        dbg_gnt = 1'b1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter for CPU, VGA fetch and debug port, with
// VGA anti-starvation promotion and a saturating CPU stall counter.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 15,
  parameter int DATA_WIDTH   = 16,
  parameter int VGA_MAX_WAIT = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  CLK_50,
  input  logic                  resetN,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  vga_req,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  output logic                  vga_gnt,
  output logic                  vga_rvalid,
  output logic [DATA_WIDTH-1:0] vga_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic                  vga_promoted
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(VGA_MAX_WAIT);

  logic                  cpu_req_v, vga_req_v, dbg_req_v;
  logic                  cpu_gnt_int;
  logic [WAIT_W-1:0]     vga_wait;
  logic [ADDR_WIDTH-1:0] addr_q;
  owner_t                owner_q, owner_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, vga_rdata_q, dbg_rdata_q;

  // Requests are masked during reset so no grant or write can leak out of it.
  assign cpu_req_v = cpu_req & resetN;
  assign vga_req_v = vga_req & resetN;
  assign dbg_req_v = dbg_req & resetN;

  assign vga_promoted = (vga_wait == WAIT_MAX);

  arb_prio3 u_prio (
    .cpu_req (cpu_req_v),
    .vga_req (vga_req_v),
    .dbg_req (dbg_req_v),
    .promote (vga_promoted),
    .cpu_gnt (cpu_gnt_int),
    .vga_gnt (vga_gnt),
    .dbg_gnt (dbg_gnt)
  );

  assign cpu_stall = cpu_req_v & ~cpu_gnt_int;

  // Idle cycles park the address on its last value so the RAM port stays quiet.
  always_comb begin
    ram_addr  = addr_q;
    ram_we    = 1'b0;
    ram_wdata = '0;
    owner_d   = OWN_NONE;
    if (cpu_gnt_int) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we;
      ram_wdata = cpu_wdata;
      if (!cpu_we) owner_d = OWN_CPU;
    end else if (vga_gnt) begin
      ram_addr = vga_addr;
      owner_d  = OWN_VGA;
    end else if (dbg_gnt) begin
      ram_addr  = dbg_addr;
      ram_we    = dbg_we;
      ram_wdata = dbg_wdata;
      if (!dbg_we) owner_d = OWN_DBG;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      addr_q      <= '0;
      owner_q     <= OWN_NONE;
      vga_wait    <= '0;
      stall_cnt   <= '0;
      cpu_rdata_q <= '0;
      vga_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      addr_q  <= ram_addr;
      owner_q <= owner_d;

      if (!vga_req || vga_gnt)     vga_wait <= '0;
      else if (vga_wait != WAIT_MAX) vga_wait <= vga_wait + WAIT_W'(1);

      if (cpu_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_WIDTH'(1);

      case (owner_q)
        OWN_CPU: cpu_rdata_q <= ram_rdata;
        OWN_VGA: vga_rdata_q <= ram_rdata;
        OWN_DBG: dbg_rdata_q <= ram_rdata;
        default: ;
      endcase
    end
  end

  assign cpu_rvalid = (owner_q == OWN_CPU);
  assign vga_rvalid = (owner_q == OWN_VGA);
  assign dbg_rvalid = (owner_q == OWN_DBG);

  assign cpu_rdata = cpu_rvalid ? ram_rdata : cpu_rdata_q;
  assign vga_rdata = vga_rvalid ? ram_rdata : vga_rdata_q;
  assign dbg_rdata = dbg_rvalid ? ram_rdata : dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: write-first RAM model, read-return
// scoreboard keyed on due cycle, plus a 4-bit-counter instance for saturation.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 15;
  localparam int DW = 16;

  logic          CLK_50 = 1'b0;
  logic          resetN;
  logic          cpu_req, cpu_we, vga_req, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, vga_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata;
  logic          cpu_stall, cpu_rvalid, vga_gnt, vga_rvalid, dbg_gnt, dbg_rvalid;
  logic [DW-1:0] cpu_rdata, vga_rdata, dbg_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic [15:0]   stall_cnt;
  logic          vga_promoted;

  logic          s_cpu_stall, s_cpu_rvalid, s_vga_gnt, s_vga_rvalid, s_dbg_gnt, s_dbg_rvalid;
  logic [DW-1:0] s_cpu_rdata, s_vga_rdata, s_dbg_rdata, s_ram_wdata;
  logic [AW-1:0] s_ram_addr;
  logic          s_ram_we, s_vga_promoted;
  logic [3:0]    s_stall_cnt;

  always #10 CLK_50 = ~CLK_50;

  dmem_arbiter u_dut (
    .CLK_50(CLK_50), .resetN(resetN),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .stall_cnt(stall_cnt), .vga_promoted(vga_promoted)
  );

  dmem_arbiter #(.CNT_WIDTH(4)) u_dut4 (
    .CLK_50(CLK_50), .resetN(resetN),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(s_cpu_stall), .cpu_rvalid(s_cpu_rvalid), .cpu_rdata(s_cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(s_vga_gnt),
    .vga_rvalid(s_vga_rvalid), .vga_rdata(s_vga_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(s_dbg_gnt), .dbg_rvalid(s_dbg_rvalid), .dbg_rdata(s_dbg_rdata),
    .ram_addr(s_ram_addr), .ram_we(s_ram_we), .ram_wdata(s_ram_wdata), .ram_rdata(ram_rdata),
    .stall_cnt(s_stall_cnt), .vga_promoted(s_vga_promoted)
  );

  // Write-first RAM with a registered read port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge CLK_50) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      ram_rdata     <= ram_wdata;
    end else begin
      ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct {
    owner_t      own;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge CLK_50) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_50);
    #1;
  endtask

  task automatic push(input owner_t o, input logic [15:0] d);
    exp_t e;
    e.own  = o;
    e.data = d;
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic idle_all();
    cpu_req = 1'b0; cpu_we = 1'b0; vga_req = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
  endtask

  // CPU and VGA both requesting: VGA wins every fifth cycle.
  task automatic contend(input int n, input bit chk);
    bit pr;
    for (int c = 0; c < n; c++) begin
      #4;
      pr = ((c % 5) == 4);
      if (chk) begin
        check("contend_vga_gnt", vga_gnt, pr);
        check("contend_cpu_stall", cpu_stall, pr);
        check("contend_promoted", vga_promoted, pr);
      end
      if (pr) push(OWN_VGA, 16'h3030);
      else    push(OWN_CPU, 16'h2020);
      tick();
    end
  endtask

  // Return monitor: each expected read must show up exactly on its due cycle.
  logic [2:0] mon_v;
  exp_t       mon_e;
  always @(negedge CLK_50) begin
    if (cyc > 2) begin
      mon_v = {cpu_rvalid, vga_rvalid, dbg_rvalid};
      if (sb.size() > 0 && sb[0].due < cyc) begin
        mon_e = sb.pop_front();
        check("rvalid_late", mon_e.due, cyc);
      end else if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        case (mon_e.own)
          OWN_CPU: begin
            check("cpu_rvalid_vec", mon_v, 3'b100);
            check("cpu_rdata", cpu_rdata, mon_e.data);
          end
          OWN_VGA: begin
            check("vga_rvalid_vec", mon_v, 3'b010);
            check("vga_rdata", vga_rdata, mon_e.data);
          end
          default: begin
            check("dbg_rvalid_vec", mon_v, 3'b001);
            check("dbg_rdata", dbg_rdata, mon_e.data);
          end
        endcase
      end else begin
        check("idle_rvalid", mon_v, 3'b000);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'(i) ^ 16'hC3C3;
    mem[15'h0010] = 16'h1234;
    mem[15'h0020] = 16'h2020;
    mem[15'h0030] = 16'h3030;
    mem[15'h0040] = 16'h4040;
    mem[15'h4000] = 16'hD00D;
    mem[15'h0005] = 16'h0505;
    mem[15'h0006] = 16'h0606;
    mem[15'h0007] = 16'h0707;

    // Reset with all requesters active: nothing may be granted.
    resetN = 1'b0;
    idle_all();
    cpu_req = 1'b1; cpu_addr = 15'h0010; cpu_wdata = '0;
    vga_req = 1'b1; vga_addr = 15'h0030;
    dbg_req = 1'b1; dbg_addr = 15'h4000; dbg_wdata = '0;
    repeat (3) tick();
    #4;
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_addr", ram_addr, 15'h0);
    check("rst_vga_gnt", vga_gnt, 1'b0);
    check("rst_dbg_gnt", dbg_gnt, 1'b0);
    check("rst_promoted", vga_promoted, 1'b0);
    check("rst_stall_cnt", stall_cnt, 16'h0);
    check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    idle_all();
    tick();
    resetN = 1'b1;

    // CPU alone: read, write, read-back.
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
    #4;
    check("cpu_rd_stall", cpu_stall, 1'b0);
    check("cpu_rd_addr", ram_addr, 15'h0010);
    check("cpu_rd_we", ram_we, 1'b0);
    push(OWN_CPU, 16'h1234);
    tick();
    cpu_we = 1'b1; cpu_addr = 15'h0011; cpu_wdata = 16'hBEEF;
    #4;
    check("cpu_wr_we", ram_we, 1'b1);
    check("cpu_wr_addr", ram_addr, 15'h0011);
    check("cpu_wr_wdata", ram_wdata, 16'hBEEF);
    tick();
    cpu_we = 1'b0;
    #4;
    check("cpu_wr_we_one_cycle", ram_we, 1'b0);
    push(OWN_CPU, 16'hBEEF);
    tick();
    idle_all();
    #4;
    check("idle_addr_hold", ram_addr, 15'h0011);
    check("idle_we", ram_we, 1'b0);
    tick();

    // CPU vs VGA contention: promotion every fifth cycle.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0020;
    vga_req = 1'b1; vga_addr = 15'h0030;
    contend(10, 1'b1);
    check("contend_stall_cnt", stall_cnt, 16'd2);
    idle_all();
    tick();

    // DBG loses to CPU, then reads and writes alone.
    cpu_req = 1'b1; cpu_addr = 15'h0040;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 15'h4000;
    for (int i = 0; i < 3; i++) begin
      #4;
      check("dbg_blocked_gnt", dbg_gnt, 1'b0);
      check("dbg_no_cpu_stall", cpu_stall, 1'b0);
      push(OWN_CPU, 16'h4040);
      tick();
    end
    cpu_req = 1'b0;
    #4;
    check("dbg_rd_gnt", dbg_gnt, 1'b1);
    push(OWN_DBG, 16'hD00D);
    tick();
    dbg_we = 1'b1; dbg_addr = 15'h4001; dbg_wdata = 16'h7777;
    #4;
    check("dbg_wr_gnt", dbg_gnt, 1'b1);
    check("dbg_wr_we", ram_we, 1'b1);
    check("dbg_wr_wdata", ram_wdata, 16'h7777);
    tick();
    idle_all();
    tick();

    // Back-to-back reads from all three requesters.
    cpu_req = 1'b1; cpu_addr = 15'h0005;
    #4;
    push(OWN_CPU, 16'h0505);
    tick();
    cpu_req = 1'b0; vga_req = 1'b1; vga_addr = 15'h0006;
    #4;
    check("b2b_vga_gnt", vga_gnt, 1'b1);
    push(OWN_VGA, 16'h0606);
    tick();
    vga_req = 1'b0; dbg_req = 1'b1; dbg_addr = 15'h0007;
    #4;
    check("b2b_dbg_gnt", dbg_gnt, 1'b1);
    push(OWN_DBG, 16'h0707);
    tick();
    idle_all();
    tick();
    tick();
    check("b2b_drained", sb.size(), 0);
    check("cpu_rdata_hold", cpu_rdata, 16'h0505);
    check("vga_rdata_hold", vga_rdata, 16'h0606);

    // Reset lands in the cycle the read would return.
    cpu_req = 1'b1; cpu_addr = 15'h0010;
    #4;
    check("pre_rst_stall", cpu_stall, 1'b0);
    tick();
    cpu_req = 1'b0;
    resetN = 1'b0;
    #1;
    check("midrd_rvalid", cpu_rvalid, 1'b0);
    check("midrd_stall_cnt", stall_cnt, 16'h0);
    check("midrd_promoted", vga_promoted, 1'b0);
    check("midrd_ram_addr", ram_addr, 15'h0);
    tick();
    resetN = 1'b1;
    cpu_req = 1'b1; cpu_addr = 15'h0010;
    #4;
    check("post_rst_stall", cpu_stall, 1'b0);
    check("post_rst_addr", ram_addr, 15'h0010);
    push(OWN_CPU, 16'h1234);
    tick();
    idle_all();
    tick();

    // Long contention: 4-bit counter saturates, 16-bit keeps counting.
    cpu_req = 1'b1; cpu_addr = 15'h0020;
    vga_req = 1'b1; vga_addr = 15'h0030;
    contend(70, 1'b0);
    check("sat4_at14", s_stall_cnt, 4'd14);
    check("cnt16_at14", stall_cnt, 16'd14);
    contend(5, 1'b0);
    check("sat4_at15", s_stall_cnt, 4'd15);
    contend(25, 1'b0);
    check("sat4_no_wrap", s_stall_cnt, 4'hF);
    check("cnt16_at20", stall_cnt, 16'd20);
    idle_all();
    tick();
    tick();
    check("final_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
